// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues in-order fetches, buffers returned words with their PCs,
// and discards in-flight responses that a redirect has made stale.
module ifetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            br_en,
  input  logic [XLEN-1:0] br_addr,
  input  logic            stall,
  output logic            exIns_ren,
  output logic [XLEN-1:0] exIns_addr,
  input  logic            exIns_valid,
  input  logic [XLEN-1:0] exIns_in,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] pc,
  output logic            err
);

  localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]     DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_M = ~(XLEN'(3));

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [AW-1:0]    fill_q, fill_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    unfilled_q, unfilled_d;
  logic [CW-1:0]    discard_q, discard_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  logic             err_q, err_d;

  logic [XLEN-1:0]  pc_mem   [DEPTH];
  logic [XLEN-1:0]  inst_mem [DEPTH];

  logic        issue, resp, drop, fill, pop, spurious, consumed;
  logic [CW:0] credit, in_flight;

  // Stale responses still in flight hold issue credit until they drain.
  assign credit    = {1'b0, count_q} + {1'b0, discard_q};
  assign in_flight = {1'b0, unfilled_q} + {1'b0, discard_q};

  assign issue    = !rst && !br_en && (credit < DEPTH_W);
  assign resp     = exIns_valid && !rst;
  assign consumed = resp && (in_flight != '0);
  assign spurious = resp && (in_flight == '0);
  assign drop     = resp && (discard_q != '0);
  assign fill     = resp && (discard_q == '0) && (unfilled_q != '0) && !br_en;
  assign pop      = filled_q[head_q] && !stall && !br_en && !rst;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_filled
      assign filled_d[gi] = br_en ? 1'b0
                          : ((filled_q[gi] && !(pop && head_q == AW'(gi)))
                             || (fill && fill_q == AW'(gi)));
    end
  endgenerate

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    fill_d     = fill_q;
    count_d    = count_q;
    unfilled_d = unfilled_q;
    discard_d  = discard_q;
    err_d      = err_q || spurious;

    if (br_en) begin
      // Everything not yet returned becomes stale, including any earlier discards.
      fetch_pc_d = br_addr & ALIGN_M;
      head_d     = '0;
      tail_d     = '0;
      fill_d     = '0;
      count_d    = '0;
      unfilled_d = '0;
      discard_d  = CW'(in_flight - {{CW{1'b0}}, consumed});
    end else begin
      if (drop) begin
        discard_d = discard_q - CW'(1);
      end
      if (fill) begin
        fill_d = fill_q + AW'(1);
      end
      if (pop) begin
        head_d = head_q + AW'(1);
      end
      if (issue) begin
        tail_d     = tail_q + AW'(1);
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end
      count_d    = count_q + {{(CW-1){1'b0}}, issue} - {{(CW-1){1'b0}}, pop};
      unfilled_d = unfilled_q + {{(CW-1){1'b0}}, issue} - {{(CW-1){1'b0}}, fill};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      count_q    <= '0;
      unfilled_q <= '0;
      discard_q  <= '0;
      filled_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_q     <= fill_d;
      count_q    <= count_d;
      unfilled_q <= unfilled_d;
      discard_q  <= discard_d;
      filled_q   <= filled_d;
      err_q      <= err_d;
    end
  end

  // Entry storage carries no reset; the filled bits alone say what is meaningful.
  always_ff @(posedge clk) begin
    if (issue) begin
      pc_mem[tail_q] <= fetch_pc_q;
    end
    if (fill) begin
      inst_mem[fill_q] <= exIns_in;
    end
  end

  assign exIns_ren  = issue;
  assign exIns_addr = fetch_pc_q;
  assign inst_valid = !rst && filled_q[head_q];
  assign inst       = rst ? '0 : inst_mem[head_q];
  assign pc         = rst ? '0 : pc_mem[head_q];
  assign err        = !rst && err_q;

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue with a small in-order memory model (1-cycle minimum latency).
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst, br_en, stall, exIns_valid;
  logic [31:0] br_addr, exIns_in;
  logic        exIns_ren, inst_valid, err;
  logic [31:0] exIns_addr, inst, pc;

  logic        u1_ren, u1_iv, u1_err;
  logic [31:0] u1_addr, u1_inst, u1_pc;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit mem_hold;
  logic [31:0] mq_addr[$];
  int          mq_t[$];

  always #5 clk = ~clk;

  ifetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .br_en(br_en), .br_addr(br_addr), .stall(stall),
    .exIns_ren(exIns_ren), .exIns_addr(exIns_addr),
    .exIns_valid(exIns_valid), .exIns_in(exIns_in),
    .inst_valid(inst_valid), .inst(inst), .pc(pc), .err(err)
  );

  ifetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u1 (
    .clk(clk), .rst(rst), .br_en(1'b0), .br_addr(32'h0), .stall(1'b1),
    .exIns_ren(u1_ren), .exIns_addr(u1_addr),
    .exIns_valid(1'b0), .exIns_in(32'h0),
    .inst_valid(u1_iv), .inst(u1_inst), .pc(u1_pc), .err(u1_err)
  );

  function automatic logic [31:0] insn(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_mem();
    if (!mem_hold && mq_addr.size() > 0 && (cyc - mq_t[0]) >= 1) begin
      exIns_valid = 1'b1;
      exIns_in    = insn(mq_addr.pop_front());
      void'(mq_t.pop_front());
    end else begin
      exIns_valid = 1'b0;
      exIns_in    = 32'h0;
    end
  endtask

  // Record this cycle's request, then move to the next falling edge and present a response.
  task automatic tick();
    if (exIns_ren) begin
      mq_addr.push_back(exIns_addr);
      mq_t.push_back(cyc);
    end
    @(negedge clk);
    cyc++;
    drive_mem();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    br_en    = 1'b0;
    stall    = 1'b0;
    mem_hold = 1'b0;
    mq_addr.delete();
    mq_t.delete();
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; br_en = 1'b0; br_addr = 32'h0; stall = 1'b0;
    exIns_valid = 1'b0; exIns_in = 32'h0; mem_hold = 1'b0;
    #1;
    // Reset state, both before and after a reset edge.
    chk("rst_ren", {31'b0, exIns_ren}, 32'd0);
    chk("rst_iv", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_err", {31'b0, err}, 32'd0);
    tick(); #1;
    chk("rst2_ren", {31'b0, exIns_ren}, 32'd0);
    chk("rst2_iv", {31'b0, inst_valid}, 32'd0);
    chk("rst2_u1_ren", {31'b0, u1_ren}, 32'd0);
    tick();
    rst = 1'b0;
    #1;

    // Streaming with 1-cycle memory; u1 shows fetch_pc wrap from 0xFFFF_FFF8.
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("stream_ren[%0d]", k), {31'b0, exIns_ren}, 32'd1);
      chk($sformatf("stream_addr[%0d]", k), exIns_addr, 32'(4 * k));
      if (k == 0) chk("wrap_addr0", u1_addr, 32'hFFFF_FFF8);
      if (k == 1) chk("wrap_addr1", u1_addr, 32'hFFFF_FFFC);
      if (k == 2) chk("wrap_addr2", u1_addr, 32'h0000_0000);
      if (k < 3)  chk($sformatf("wrap_ren[%0d]", k), {31'b0, u1_ren}, 32'd1);
      if (k >= 2) begin
        chk($sformatf("stream_iv[%0d]", k), {31'b0, inst_valid}, 32'd1);
        chk($sformatf("stream_pc[%0d]", k), pc, 32'(4 * (k - 2)));
        chk($sformatf("stream_inst[%0d]", k), inst, insn(32'(4 * (k - 2))));
      end else begin
        chk($sformatf("stream_iv[%0d]", k), {31'b0, inst_valid}, 32'd0);
      end
      tick(); #1;
    end

    // Stall held: exactly four requests, head stays at pc 0.
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("stall_ren[%0d]", i), {31'b0, exIns_ren}, (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) chk($sformatf("stall_addr[%0d]", i), exIns_addr, 32'(4 * i));
      if (i >= 2) begin
        chk($sformatf("stall_iv[%0d]", i), {31'b0, inst_valid}, 32'd1);
        chk($sformatf("stall_pc[%0d]", i), pc, 32'h0);
      end
      tick(); #1;
    end
    stall = 1'b0;
    chk("unstall_ren0", {31'b0, exIns_ren}, 32'd0);
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("unstall_iv[%0d]", j), {31'b0, inst_valid}, 32'd1);
      chk($sformatf("unstall_pc[%0d]", j), pc, 32'(4 * j));
      chk($sformatf("unstall_inst[%0d]", j), inst, insn(32'(4 * j)));
      if (j == 1) begin
        chk("resume_ren", {31'b0, exIns_ren}, 32'd1);
        chk("resume_addr", exIns_addr, 32'h10);
      end
      tick(); #1;
    end

    // Redirect with three fetches outstanding: stale responses must be dropped.
    do_reset();
    mem_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("br3_addr[%0d]", i), exIns_addr, 32'(4 * i));
      tick(); #1;
    end
    br_en = 1'b1; br_addr = 32'h0000_0103;
    #1;
    chk("br3_ren_blocked", {31'b0, exIns_ren}, 32'd0);
    mem_hold = 1'b0;
    tick();
    br_en = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("br3_iv[%0d]", i), {31'b0, inst_valid}, 32'd0);
      if (i < 3) begin
        chk($sformatf("br3_ren[%0d]", i), {31'b0, exIns_ren}, 32'd1);
        chk($sformatf("br3_new_addr[%0d]", i), exIns_addr, 32'h100 + 32'(4 * i));
      end
      tick(); #1;
    end
    chk("br3_first_iv", {31'b0, inst_valid}, 32'd1);
    chk("br3_first_pc", pc, 32'h100);
    chk("br3_first_inst", inst, insn(32'h100));
    chk("br3_err", {31'b0, err}, 32'd0);

    // Redirect in the same cycle as a response, two unfilled: one later drop.
    do_reset();
    mem_hold = 1'b1;
    chk("brv_addr0", exIns_addr, 32'h0);
    tick(); #1;
    chk("brv_addr1", exIns_addr, 32'h4);
    mem_hold = 1'b0;
    tick();
    br_en = 1'b1; br_addr = 32'h0000_0200;
    #1;
    chk("brv_resp_present", {31'b0, exIns_valid}, 32'd1);
    chk("brv_ren_blocked", {31'b0, exIns_ren}, 32'd0);
    tick();
    br_en = 1'b0;
    #1;
    chk("brv_addr_new", exIns_addr, 32'h200);
    chk("brv_iv0", {31'b0, inst_valid}, 32'd0);
    tick(); #1;
    chk("brv_iv1", {31'b0, inst_valid}, 32'd0);
    tick(); #1;
    chk("brv_iv2", {31'b0, inst_valid}, 32'd1);
    chk("brv_pc", pc, 32'h200);
    chk("brv_inst", inst, insn(32'h200));
    chk("brv_err", {31'b0, err}, 32'd0);

    // Spurious response with nothing outstanding: sticky err, queue contents untouched.
    do_reset();
    exIns_valid = 1'b1; exIns_in = 32'h0000_0BAD;
    #1;
    chk("spur_err_before", {31'b0, err}, 32'd0);
    tick(); #1;
    chk("spur_err_set", {31'b0, err}, 32'd1);
    chk("spur_iv", {31'b0, inst_valid}, 32'd0);
    tick(); #1;
    chk("spur_err_held", {31'b0, err}, 32'd1);
    chk("spur_q_iv", {31'b0, inst_valid}, 32'd1);
    chk("spur_q_pc", pc, 32'h0);
    chk("spur_q_inst", inst, insn(32'h0));
    tick(); #1;
    chk("spur_err_held2", {31'b0, err}, 32'd1);
    rst = 1'b1;
    #1;
    chk("spur_err_in_rst", {31'b0, err}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("spur_err_cleared", {31'b0, err}, 32'd0);
    chk("spur_reset_addr", exIns_addr, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
